// File: rtl/bw_clk_cl_hdr_seq.sv
// Clock-cluster header sequencer: staggered header enables, delayed cluster
// reset release, reverse-order ramp-down and timed debug-init pulses.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | all headers off, cluster in reset, waiting for request
// S_RAMP_UP | enabling headers upward, one every STAGGER cycles
// S_HOLD    | all headers on, holding cluster reset for RST_HOLD cycles
// S_RUN     | cluster up, accepting debug-init requests
// S_DBG     | debug-init pulse low for DBG_LEN cycles
// S_RAMP_DN | disabling headers downward, one every STAGGER cycles
module bw_clk_cl_hdr_seq #(
    parameter int NUM_HDR  = 2,
    parameter int STAGGER  = 4,
    parameter int RST_HOLD = 8,
    parameter int DBG_LEN  = 3
) (
    input  logic               rclk,
    input  logic               grst,
    input  logic               cluster_cken_req,
    input  logic               dbginit_req,
    output logic [NUM_HDR-1:0] hdr_cken,
    output logic               cluster_grst_l,
    output logic               dbginit_l,
    output logic               seq_busy,
    output logic               seq_done
);

    localparam int M1      = (STAGGER > RST_HOLD) ? STAGGER : RST_HOLD;
    localparam int CNT_MAX = (M1 > DBG_LEN) ? M1 : DBG_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_HDR > 1) ? $clog2(NUM_HDR) : 1;

    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
    localparam logic [CW-1:0] STG_TC   = CW'(STAGGER - 1);
    localparam logic [CW-1:0] HOLD_TC  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DBG_TC   = CW'(DBG_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_HDR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD,
        S_RUN,
        S_DBG,
        S_RAMP_DN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d, idx_inc;
    logic [NUM_HDR-1:0]  hdr_q, hdr_d;
    logic                grst_l_q, grst_l_d;
    logic                dbg_l_q, dbg_l_d;
    logic                dn_entry;

    always_ff @(posedge rclk) begin
        if (grst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            hdr_q    <= '0;
            grst_l_q <= 1'b0;
            dbg_l_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            hdr_q    <= hdr_d;
            grst_l_q <= grst_l_d;
            dbg_l_q  <= dbg_l_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
        idx_d    = idx_q;
        idx_inc  = idx_q + 1'b1;
        hdr_d    = hdr_q;
        grst_l_d = grst_l_q;
        dbg_l_d  = dbg_l_q;
        dn_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cluster_cken_req) begin
                    hdr_d[0] = 1'b1;
                    idx_d    = '0;
                    state_d  = (NUM_HDR == 1) ? S_HOLD : S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (!cluster_cken_req) begin
                    dn_entry = 1'b1;
                end else if (cnt_q == STG_TC) begin
                    idx_d          = idx_inc;
                    hdr_d[idx_inc] = 1'b1;
                    cnt_d          = '0;
                    if (idx_inc == LAST_IDX) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!cluster_cken_req) begin
                    dn_entry = 1'b1;
                end else if (cnt_q == HOLD_TC) begin
                    grst_l_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (!cluster_cken_req) begin
                    dn_entry = 1'b1;
                end else if (dbginit_req) begin
                    dbg_l_d = 1'b0;
                    state_d = S_DBG;
                end
            end
            S_DBG: begin
                if (!cluster_cken_req) begin
                    dn_entry = 1'b1;
                end else if (cnt_q == DBG_TC) begin
                    dbg_l_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RAMP_DN: begin
                if (cnt_q == STG_TC) begin
                    hdr_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ramp-down entry drops the top header on the same edge that pulls reset.
        if (dn_entry) begin
            grst_l_d     = 1'b0;
            dbg_l_d      = 1'b1;
            hdr_d[idx_q] = 1'b0;
            if (idx_q == '0) begin
                state_d = S_IDLE;
            end else begin
                idx_d   = idx_q - 1'b1;
                state_d = S_RAMP_DN;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign hdr_cken       = hdr_q;
    assign cluster_grst_l = grst_l_q;
    assign dbginit_l      = dbg_l_q;
    assign seq_busy       = (state_q == S_RAMP_UP) || (state_q == S_HOLD) ||
                            (state_q == S_RAMP_DN);
    assign seq_done       = grst_l_q;

endmodule

// File: tb/tb_bw_clk_cl_hdr_seq.sv
// Bench for bw_clk_cl_hdr_seq: two parameterisations share one stimulus stream
// and are compared each cycle against a time-based reference model.
module tb_bw_clk_cl_hdr_seq;

    localparam int A_N = 2, A_S = 4, A_H = 8, A_L = 3;
    localparam int B_N = 4, B_S = 2, B_H = 5, B_L = 2;

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_RUN  = 2;
    localparam int M_DOWN = 3;

    typedef struct packed {
        logic [3:0] hdr;
        logic       grst_l;
        logic       dbg_l;
        logic       busy;
        logic       done;
    } obs_t;

    logic rclk = 1'b0;
    logic grst = 1'b1;
    logic cluster_cken_req = 1'b0;
    logic dbginit_req = 1'b0;

    logic [A_N-1:0] hdr_a;
    logic           grst_l_a, dbg_l_a, busy_a, done_a;
    logic [B_N-1:0] hdr_b;
    logic           grst_l_b, dbg_l_b, busy_b, done_b;

    always #5 rclk = ~rclk;

    bw_clk_cl_hdr_seq #(.NUM_HDR(A_N), .STAGGER(A_S), .RST_HOLD(A_H), .DBG_LEN(A_L)) dut_a (
        .rclk(rclk), .grst(grst), .cluster_cken_req(cluster_cken_req), .dbginit_req(dbginit_req),
        .hdr_cken(hdr_a), .cluster_grst_l(grst_l_a), .dbginit_l(dbg_l_a),
        .seq_busy(busy_a), .seq_done(done_a));

    bw_clk_cl_hdr_seq #(.NUM_HDR(B_N), .STAGGER(B_S), .RST_HOLD(B_H), .DBG_LEN(B_L)) dut_b (
        .rclk(rclk), .grst(grst), .cluster_cken_req(cluster_cken_req), .dbginit_req(dbginit_req),
        .hdr_cken(hdr_b), .cluster_grst_l(grst_l_b), .dbginit_l(dbg_l_b),
        .seq_busy(busy_b), .seq_done(done_b));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    obs_t exp_a_q[$];
    obs_t exp_b_q[$];
    int   cyc_q[$];

    // Model: per-instance phase plus the cycle its timing started from.
    int m_mode[2], m_t0[2], m_td[2], m_kd[2], m_ones[2], m_dend[2];
    bit m_grst[2], m_dbgl[2];

    task automatic down_entry(input int i);
        m_ones[i] = m_ones[i] - 1;
        m_grst[i] = 1'b0;
        m_dbgl[i] = 1'b1;
        m_dend[i] = -100;
        if (m_ones[i] <= 0) begin
            m_ones[i] = 0;
            m_mode[i] = M_OFF;
        end else begin
            m_mode[i] = M_DOWN;
            m_td[i]   = cyc;
            m_kd[i]   = m_ones[i];
        end
    endtask

    task automatic model_step(input int i, input bit g, input bit r, input bit d);
        int nh, st, ho, dl, el;
        nh = (i == 0) ? A_N : B_N;
        st = (i == 0) ? A_S : B_S;
        ho = (i == 0) ? A_H : B_H;
        dl = (i == 0) ? A_L : B_L;
        if (g) begin
            m_mode[i] = M_OFF; m_ones[i] = 0; m_grst[i] = 1'b0;
            m_dbgl[i] = 1'b1;  m_dend[i] = -100;
            return;
        end
        if (m_mode[i] == M_OFF && r) begin
            m_mode[i] = M_UP;
            m_t0[i]   = cyc;
        end
        case (m_mode[i])
            M_UP: begin
                if (!r) begin
                    down_entry(i);
                end else begin
                    el = cyc - m_t0[i];
                    m_ones[i] = 1 + el / st;
                    if (m_ones[i] > nh) m_ones[i] = nh;
                    if (el >= (nh - 1) * st + ho) begin
                        m_grst[i] = 1'b1;
                        m_mode[i] = M_RUN;
                    end
                end
            end
            M_RUN: begin
                if (!r) begin
                    down_entry(i);
                end else begin
                    if (cyc > m_dend[i] && d) m_dend[i] = cyc + dl;
                    m_dbgl[i] = (cyc < m_dend[i]) ? 1'b0 : 1'b1;
                end
            end
            M_DOWN: begin
                m_ones[i] = m_kd[i] - (cyc - m_td[i]) / st;
                if (m_ones[i] <= 0) begin
                    m_ones[i] = 0;
                    m_mode[i] = M_OFF;
                end
            end
            default: ;
        endcase
    endtask

    function automatic obs_t model_obs(input int i);
        obs_t o;
        o.hdr    = 4'((1 << m_ones[i]) - 1);
        o.grst_l = m_grst[i];
        o.dbg_l  = m_dbgl[i];
        o.busy   = (m_mode[i] == M_UP) || (m_mode[i] == M_DOWN);
        o.done   = m_grst[i];
        return o;
    endfunction

    task automatic step(input bit g, input bit r, input bit d);
        grst = g;
        cluster_cken_req = r;
        dbginit_req = d;
        @(posedge rclk);
        cyc++;
        model_step(0, g, r, d);
        model_step(1, g, r, d);
        exp_a_q.push_back(model_obs(0));
        exp_b_q.push_back(model_obs(1));
        cyc_q.push_back(cyc);
        #1;
    endtask

    task automatic run_cycles(input int cnt, input bit r);
        for (int k = 0; k < cnt; k++) step(1'b0, r, 1'b0);
    endtask

    always @(negedge rclk) begin
        obs_t ea, eb, aa, ab;
        int   c;
        if (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            c  = cyc_q.pop_front();
            aa = '{hdr: {2'b00, hdr_a}, grst_l: grst_l_a, dbg_l: dbg_l_a, busy: busy_a, done: done_a};
            ab = '{hdr: hdr_b, grst_l: grst_l_b, dbg_l: dbg_l_b, busy: busy_b, done: done_b};
            checks++;
            if (aa !== ea) begin
                errors++;
                $display("FAIL dut_a cycle %0d actual=%b expected=%b (hdr,grst_l,dbginit_l,busy,done)", c, aa, ea);
            end
            checks++;
            if (ab !== eb) begin
                errors++;
                $display("FAIL dut_b cycle %0d actual=%b expected=%b (hdr,grst_l,dbginit_l,busy,done)", c, ab, eb);
            end
        end
    end

    initial begin
        bit r, d, g;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_OFF; m_ones[i] = 0; m_grst[i] = 1'b0;
            m_dbgl[i] = 1'b1;  m_dend[i] = -100; m_t0[i] = 0;
            m_td[i] = 0; m_kd[i] = 0;
        end

        // reset, then a full default ramp-up held into RUN
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_cycles(2, 1'b0);
        run_cycles(18, 1'b1);

        // debug pulse, a second request during it, then a later one
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        run_cycles(5, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run_cycles(4, 1'b1);

        // simultaneous drop and debug request, then a full ramp-down
        step(1'b0, 1'b0, 1'b1);
        run_cycles(12, 1'b0);

        // abort during ramp-up: request sampled at E0, E1, dropped at E2
        run_cycles(2, 1'b1);
        run_cycles(10, 1'b0);

        // re-request during ramp-down is ignored until IDLE
        run_cycles(20, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run_cycles(3, 1'b1);
        run_cycles(10, 1'b1);

        // reset during HOLD with the request held through release
        run_cycles(8, 1'b0);
        run_cycles(7, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run_cycles(20, 1'b1);

        // reset during DBG
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run_cycles(3, 1'b0);

        r = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0) r = ~r;
            d = ($urandom_range(0, 5) == 0);
            g = ($urandom_range(0, 199) == 0);
            step(g, r, d);
        end

        @(negedge rclk);
        @(negedge rclk);
        checks++;
        if (exp_a_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_a_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
